// File: rtl/imm_gen_pipe_if.sv
// Producer/consumer bundle for imm_gen_pipe: raw instruction in, decoded immediate out.
// Handshake: a beat transfers on a rising edge where valid && ready; valid never waits on ready.
interface imm_gen_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_inst;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    logic [2:0]       out_fmt;
    logic             out_illegal;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_inst, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
    );

    modport slave (
        input  in_valid, in_inst, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// RISC-V immediate decoder feeding a small FIFO, so ID-stage decode is decoupled
// from EX-stage back-pressure. Counts accepted illegal opcodes.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter int TAG_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    imm_gen_pipe_if.slave      bus,
    output logic [15:0]        illegal_cnt
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam bit IS64  = (XLEN == 64);

    typedef enum logic [2:0] {
        FMT_NONE  = 3'd0,
        FMT_I     = 3'd1,
        FMT_S     = 3'd2,
        FMT_B     = 3'd3,
        FMT_U     = 3'd4,
        FMT_J     = 3'd5,
        FMT_SHAMT = 3'd6
    } fmt_e;

    logic [31:0]     inst;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [31:0]     dec_raw;
    logic [XLEN-1:0] dec_imm;
    fmt_e            dec_fmt;
    logic            dec_illegal;
    logic            is_shift;

    assign inst     = bus.in_inst;
    assign opcode   = inst[6:0];
    assign funct3   = inst[14:12];
    assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

    // Every format fits in 32 bits with its sign at bit 31, so one sign extension serves all.
    always_comb begin
        dec_fmt     = FMT_NONE;
        dec_raw     = '0;
        dec_illegal = 1'b0;
        case (opcode)
            7'b0000011, 7'b1100111, 7'b1110011: begin
                dec_fmt = FMT_I;
                dec_raw = {{20{inst[31]}}, inst[31:20]};
            end
            7'b0010011: begin
                if (is_shift) begin
                    dec_fmt = FMT_SHAMT;
                    dec_raw = IS64 ? {26'b0, inst[25:20]} : {27'b0, inst[24:20]};
                end else begin
                    dec_fmt = FMT_I;
                    dec_raw = {{20{inst[31]}}, inst[31:20]};
                end
            end
            7'b0011011: begin
                if (!IS64) begin
                    dec_illegal = 1'b1;
                end else if (is_shift) begin
                    dec_fmt = FMT_SHAMT;
                    dec_raw = {27'b0, inst[24:20]};
                end else begin
                    dec_fmt = FMT_I;
                    dec_raw = {{20{inst[31]}}, inst[31:20]};
                end
            end
            7'b0100011: begin
                dec_fmt = FMT_S;
                dec_raw = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            end
            7'b1100011: begin
                dec_fmt = FMT_B;
                dec_raw = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                dec_fmt = FMT_U;
                dec_raw = {inst[31:12], 12'b0};
            end
            7'b1101111: begin
                dec_fmt = FMT_J;
                dec_raw = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    assign dec_imm = XLEN'($signed(dec_raw));

    logic [XLEN-1:0]  mem_imm [DEPTH];
    fmt_e             mem_fmt [DEPTH];
    logic             mem_ill [DEPTH];
    logic [TAG_W-1:0] mem_tag [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             push;
    logic             pop;

    assign bus.in_ready  = rst && (count < (PTR_W+1)'(DEPTH)) && !flush;
    assign bus.out_valid = (count != '0);
    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_imm[wr_ptr] <= dec_imm;
            mem_fmt[wr_ptr] <= dec_fmt;
            mem_ill[wr_ptr] <= dec_illegal;
            mem_tag[wr_ptr] <= bus.in_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            illegal_cnt <= '0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
                case ({push, pop})
                    2'b10:   count <= count + (PTR_W+1)'(1);
                    2'b01:   count <= count - (PTR_W+1)'(1);
                    default: count <= count;
                endcase
            end
            if (push && dec_illegal && (illegal_cnt != 16'hFFFF))
                illegal_cnt <= illegal_cnt + 16'd1;
        end
    end

    // While empty the outputs replay whatever the head showed last (zero after reset).
    logic [XLEN-1:0]  last_imm;
    fmt_e             last_fmt;
    logic             last_ill;
    logic [TAG_W-1:0] last_tag;

    always_ff @(posedge clk) begin
        if (!rst) begin
            last_imm <= '0;
            last_fmt <= FMT_NONE;
            last_ill <= 1'b0;
            last_tag <= '0;
        end else if (bus.out_valid) begin
            last_imm <= mem_imm[rd_ptr];
            last_fmt <= mem_fmt[rd_ptr];
            last_ill <= mem_ill[rd_ptr];
            last_tag <= mem_tag[rd_ptr];
        end
    end

    assign bus.out_imm     = bus.out_valid ? mem_imm[rd_ptr] : last_imm;
    assign bus.out_fmt     = bus.out_valid ? mem_fmt[rd_ptr] : last_fmt;
    assign bus.out_illegal = bus.out_valid ? mem_ill[rd_ptr] : last_ill;
    assign bus.out_tag     = bus.out_valid ? mem_tag[rd_ptr] : last_tag;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// Drives an XLEN=32 and an XLEN=64 instance with identical stimulus and checks both
// against an arithmetic decode model and a queue model of the buffer.
module tb_imm_gen_pipe;
    localparam int DEPTH = 2;
    localparam int TAG_W = 5;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    logic in_valid;
    logic [31:0] in_inst;
    logic [TAG_W-1:0] in_tag;
    logic out_ready;
    logic [15:0] ill_cnt32;
    logic [15:0] ill_cnt64;

    always #5 clk = ~clk;

    imm_gen_pipe_if #(.XLEN(32), .TAG_W(TAG_W)) if32 ();
    imm_gen_pipe_if #(.XLEN(64), .TAG_W(TAG_W)) if64 ();

    assign if32.in_valid  = in_valid;
    assign if32.in_inst   = in_inst;
    assign if32.in_tag    = in_tag;
    assign if32.out_ready = out_ready;
    assign if64.in_valid  = in_valid;
    assign if64.in_inst   = in_inst;
    assign if64.in_tag    = in_tag;
    assign if64.out_ready = out_ready;

    imm_gen_pipe #(.XLEN(32), .DEPTH(DEPTH), .TAG_W(TAG_W)) u_dut32 (
        .clk(clk), .rst(rst), .flush(flush), .bus(if32), .illegal_cnt(ill_cnt32)
    );
    imm_gen_pipe #(.XLEN(64), .DEPTH(DEPTH), .TAG_W(TAG_W)) u_dut64 (
        .clk(clk), .rst(rst), .flush(flush), .bus(if64), .illegal_cnt(ill_cnt64)
    );

    // Scoreboard: {tag, inst} of buffered entries, head first.
    logic [TAG_W+31:0] exp_q[$];
    logic [TAG_W+31:0] shown;
    bit                shown_zero;
    int                exp_ic32;
    int                exp_ic64;
    bit                accepted;
    int                n_checks = 0;
    int                n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    endtask

    function automatic longint sext(input longint val, input int bits);
        if (val >= (longint'(1) <<< (bits - 1))) return val - (longint'(1) <<< bits);
        return val;
    endfunction

    function automatic void ref_dec(input logic [31:0] i, input bit x64,
                                    output logic [63:0] imm, output logic [2:0] fmt,
                                    output logic ill);
        longint v;
        bit shift;
        v = 0;
        fmt = 3'd0;
        ill = 1'b0;
        shift = (i[14:12] == 3'b001) || (i[14:12] == 3'b101);
        case (i[6:0])
            7'h03, 7'h67, 7'h73: begin fmt = 3'd1; v = sext(longint'(i[31:20]), 12); end
            7'h13: begin
                if (shift) begin
                    fmt = 3'd6;
                    v = x64 ? longint'(i[25:20]) : longint'(i[24:20]);
                end else begin
                    fmt = 3'd1; v = sext(longint'(i[31:20]), 12);
                end
            end
            7'h1B: begin
                if (!x64) ill = 1'b1;
                else if (shift) begin fmt = 3'd6; v = longint'(i[24:20]); end
                else begin fmt = 3'd1; v = sext(longint'(i[31:20]), 12); end
            end
            7'h23: begin fmt = 3'd2; v = sext(longint'(i[31:25]) * 32 + longint'(i[11:7]), 12); end
            7'h63: begin
                fmt = 3'd3;
                v = sext(longint'(i[11:8]) * 2 + longint'(i[30:25]) * 32
                         + longint'(i[7]) * 2048 + longint'(i[31]) * 4096, 13);
            end
            7'h37, 7'h17: begin fmt = 3'd4; v = sext(longint'(i[31:12]) * 4096, 32); end
            7'h6F: begin
                fmt = 3'd5;
                v = sext(longint'(i[30:21]) * 2 + longint'(i[20]) * 2048
                         + longint'(i[19:12]) * 4096 + longint'(i[31]) * 1048576, 21);
            end
            default: ill = 1'b1;
        endcase
        imm = x64 ? 64'(v) : {32'b0, 32'(v)};
    endfunction

    task automatic check_outputs();
        logic [63:0] e_imm;
        logic [2:0]  e_fmt;
        logic        e_ill;
        logic [TAG_W+31:0] head;
        bit zero;
        bit rdy;
        rdy = rst && (exp_q.size() < DEPTH) && !flush;
        check("in_ready32", 64'(if32.in_ready), 64'(rdy));
        check("in_ready64", 64'(if64.in_ready), 64'(rdy));
        check("out_valid32", 64'(if32.out_valid), 64'(exp_q.size() != 0));
        check("out_valid64", 64'(if64.out_valid), 64'(exp_q.size() != 0));
        check("illegal_cnt32", 64'(ill_cnt32), 64'(exp_ic32));
        check("illegal_cnt64", 64'(ill_cnt64), 64'(exp_ic64));
        if (exp_q.size() != 0) begin head = exp_q[0]; zero = 1'b0; end
        else begin head = shown; zero = shown_zero; end
        for (int x = 0; x < 2; x++) begin
            ref_dec(head[31:0], x == 1, e_imm, e_fmt, e_ill);
            if (zero) begin e_imm = '0; e_fmt = '0; e_ill = 1'b0; end
            if (x == 0) begin
                check("imm32", 64'(if32.out_imm), e_imm);
                check("fmt32", 64'(if32.out_fmt), 64'(e_fmt));
                check("ill32", 64'(if32.out_illegal), 64'(e_ill));
                check("tag32", 64'(if32.out_tag), zero ? 64'(0) : 64'(head[TAG_W+31:32]));
            end else begin
                check("imm64", if64.out_imm, e_imm);
                check("fmt64", 64'(if64.out_fmt), 64'(e_fmt));
                check("ill64", 64'(if64.out_illegal), 64'(e_ill));
                check("tag64", 64'(if64.out_tag), zero ? 64'(0) : 64'(head[TAG_W+31:32]));
            end
        end
    endtask

    // One clock: check outputs mid-cycle, then advance the model across the edge.
    task automatic step();
        bit push;
        bit pop;
        logic [63:0] d_imm;
        logic [2:0]  d_fmt;
        logic        d_ill;
        @(negedge clk);
        check_outputs();
        push = in_valid && rst && !flush && (exp_q.size() < DEPTH);
        pop  = (exp_q.size() != 0) && out_ready;
        accepted = push;
        @(posedge clk);
        if (!rst) begin
            exp_q.delete();
            shown_zero = 1'b1;
            exp_ic32 = 0;
            exp_ic64 = 0;
        end else begin
            if (exp_q.size() != 0) begin shown = exp_q[0]; shown_zero = 1'b0; end
            if (flush) exp_q.delete();
            else begin
                if (pop) void'(exp_q.pop_front());
                if (push) begin
                    exp_q.push_back({in_tag, in_inst});
                    ref_dec(in_inst, 1'b0, d_imm, d_fmt, d_ill);
                    if (d_ill && exp_ic32 < 65535) exp_ic32++;
                    ref_dec(in_inst, 1'b1, d_imm, d_fmt, d_ill);
                    if (d_ill && exp_ic64 < 65535) exp_ic64++;
                end
            end
        end
        #1;
    endtask

    task automatic push_word(input logic [31:0] w, input bit ordy);
        int tries;
        in_valid = 1'b1;
        in_inst = w;
        in_tag = TAG_W'($urandom);
        out_ready = ordy;
        tries = 0;
        accepted = 1'b0;
        while (!accepted && tries < 20) begin
            step();
            tries++;
        end
        if (!accepted) check("push_timeout", 64'(0), 64'(1));
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n, input bit ordy);
        in_valid = 1'b0;
        out_ready = ordy;
        repeat (n) step();
    endtask

    function automatic logic [31:0] rand_inst();
        logic [6:0] ops [10];
        logic [31:0] w;
        int sel;
        ops = '{7'h03, 7'h67, 7'h73, 7'h13, 7'h1B, 7'h23, 7'h63, 7'h37, 7'h6F, 7'h17};
        w = $urandom;
        sel = $urandom_range(0, 11);
        if (sel < 10) w[6:0] = ops[sel];
        if ($urandom_range(0, 1) == 1) w[14:12] = ($urandom_range(0, 1) == 1) ? 3'b001 : 3'b101;
        return w;
    endfunction

    initial begin
        logic [31:0] plan_a [5];
        logic [31:0] plan_b [4];
        plan_a = '{32'hFFF00093, 32'hFE000EE3, 32'h4030D093, 32'h12345037, 32'hFF9FF06F};
        plan_b = '{32'h00000000, 32'h0000001B, 32'h03F09093, 32'h800000B7};
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_tag = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        shown = '0; shown_zero = 1'b1; exp_ic32 = 0; exp_ic64 = 0;
        step();
        rst = 1'b1;

        foreach (plan_a[k]) push_word(plan_a[k], 1'b1);
        idle(2, 1'b1);

        push_word(32'h00100093, 1'b0);
        push_word(32'h00200113, 1'b0);
        in_valid = 1'b1; in_inst = 32'h00300193; out_ready = 1'b0;
        step();
        step();
        push_word(32'h00300193, 1'b1);
        idle(3, 1'b1);

        foreach (plan_b[k]) push_word(plan_b[k], 1'b1);
        idle(2, 1'b1);

        push_word(32'h0000007F, 1'b0);
        push_word(32'h00000013, 1'b0);
        flush = 1'b1; in_valid = 1'b1; in_inst = 32'h00000000;
        step();
        flush = 1'b0; in_valid = 1'b0;
        idle(2, 1'b0);

        push_word(32'h0000007F, 1'b0);
        rst = 1'b0;
        step();
        rst = 1'b1;
        idle(2, 1'b1);

        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_inst   = rand_inst();
            in_tag    = TAG_W'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            rst       = ($urandom_range(0, 299) != 0);
            step();
        end
        rst = 1'b1; flush = 1'b0;
        idle(3, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
